// File: rtl/datecounter_if.sv
// Control and status bundle between the calendar counter and its user
// (time counter / edit controller / display mux).
interface datecounter_if;
    logic       dayroll;
    logic       freeze;
    logic       inc;
    logic       dec;
    logic [1:0] sel;
    logic [4:0] dd;
    logic [3:0] mo;
    logic [6:0] yy;
    logic [4:0] dim;
    logic       newyear;

    modport master (
        output dayroll, freeze, inc, dec, sel,
        input  dd, mo, yy, dim, newyear
    );

    modport slave (
        input  dayroll, freeze, inc, dec, sel,
        output dd, mo, yy, dim, newyear
    );
endinterface

// File: rtl/datecounter.sv
// Day/month/year calendar for 2000..2099, advanced by the time counter's
// dayroll pulse and editable field-by-field while frozen.
module datecounter #(
    parameter int unsigned RESET_DAY   = 1,
    parameter int unsigned RESET_MONTH = 1,
    parameter int unsigned RESET_YEAR  = 0
) (
    input  logic         clk,
    input  logic         rst,
    datecounter_if.slave bus
);

    logic [4:0] dd_q, dd_d;
    logic [3:0] mo_q, mo_d;
    logic [6:0] yy_q, yy_d;
    logic       newyear_q, newyear_d;
    logic [4:0] dim_q, dim_new;

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
            4'd2:                    days_in = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 days_in = 5'd31;
        endcase
    endfunction

    assign dim_q = days_in(mo_q, yy_q);

    always_comb begin
        dd_d      = dd_q;
        mo_d      = mo_q;
        yy_d      = yy_q;
        newyear_d = 1'b0;
        dim_new   = 5'd0;
        if (!bus.freeze) begin
            if (bus.dayroll) begin
                if (dd_q < dim_q) begin
                    dd_d = dd_q + 5'd1;
                end else begin
                    dd_d = 5'd1;
                    if (mo_q < 4'd12) begin
                        mo_d = mo_q + 4'd1;
                    end else begin
                        mo_d      = 4'd1;
                        yy_d      = (yy_q == 7'd99) ? 7'd0 : yy_q + 7'd1;
                        newyear_d = 1'b1;
                    end
                end
            end
        end else if (bus.inc ^ bus.dec) begin
            unique case (bus.sel)
                2'b01: begin
                    if (bus.inc) dd_d = (dd_q >= dim_q) ? 5'd1 : dd_q + 5'd1;
                    else         dd_d = (dd_q <= 5'd1) ? dim_q : dd_q - 5'd1;
                end
                2'b10: begin
                    if (bus.inc) mo_d = (mo_q >= 4'd12) ? 4'd1 : mo_q + 4'd1;
                    else         mo_d = (mo_q <= 4'd1) ? 4'd12 : mo_q - 4'd1;
                end
                2'b11: begin
                    if (bus.inc) yy_d = (yy_q >= 7'd99) ? 7'd0 : yy_q + 7'd1;
                    else         yy_d = (yy_q == 7'd0) ? 7'd99 : yy_q - 7'd1;
                end
                default: ;
            endcase
        end
        // Clamp against the month/year being written so a month or year edit
        // never leaves an impossible date; a no-op for rollover and day edits.
        dim_new = days_in(mo_d, yy_d);
        if (dd_d > dim_new) dd_d = dim_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dd_q      <= 5'(RESET_DAY);
            mo_q      <= 4'(RESET_MONTH);
            yy_q      <= 7'(RESET_YEAR);
            newyear_q <= 1'b0;
        end else begin
            dd_q      <= dd_d;
            mo_q      <= mo_d;
            yy_q      <= yy_d;
            newyear_q <= newyear_d;
        end
    end

    assign bus.dd      = dd_q;
    assign bus.mo      = mo_q;
    assign bus.yy      = yy_q;
    assign bus.dim     = dim_q;
    assign bus.newyear = newyear_q;

endmodule

// File: tb/tb_datecounter.sv
// Bench for datecounter: directed calendar cases plus random traffic, all
// checked against a calendar model kept in plain integer arithmetic.
module tb_datecounter;

    logic clk;
    logic rst;
    datecounter_if bus ();

    datecounter #(
        .RESET_DAY  (1),
        .RESET_MONTH(1),
        .RESET_YEAR (0)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int m_dd, m_mo, m_yy, m_ny;
    int ny_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mdays(input int m, input int y);
        int tbl [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && (y % 4) == 0) return 29;
        return tbl[m - 1];
    endfunction

    task automatic model_reset();
        m_dd = 1; m_mo = 1; m_yy = 0; m_ny = 0;
    endtask

    task automatic model_step(input int dr, input int fr, input int i, input int d, input int s);
        int n;
        m_ny = 0;
        if (fr == 0) begin
            if (dr != 0) begin
                if (m_dd < mdays(m_mo, m_yy)) m_dd++;
                else begin
                    m_dd = 1;
                    if (m_mo < 12) m_mo++;
                    else begin
                        m_mo = 1;
                        m_yy = (m_yy + 1) % 100;
                        m_ny = 1;
                    end
                end
            end
        end else if (i != d) begin
            n = mdays(m_mo, m_yy);
            case (s)
                1: m_dd = (i != 0) ? (m_dd % n) + 1 : ((m_dd + n - 2) % n) + 1;
                2: m_mo = (i != 0) ? (m_mo % 12) + 1 : ((m_mo + 10) % 12) + 1;
                3: m_yy = (i != 0) ? (m_yy + 1) % 100 : (m_yy + 99) % 100;
                default: ;
            endcase
            n = mdays(m_mo, m_yy);
            if (m_dd > n) m_dd = n;
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".dd"}, int'(bus.dd), m_dd);
        chk({tag, ".mo"}, int'(bus.mo), m_mo);
        chk({tag, ".yy"}, int'(bus.yy), m_yy);
        chk({tag, ".dim"}, int'(bus.dim), mdays(m_mo, m_yy));
        chk({tag, ".ny"}, int'(bus.newyear), m_ny);
    endtask

    // One clock: drive on the falling edge, check 1 ns after the rising edge.
    task automatic step(input string tag, input int dr, input int fr, input int i,
                        input int d, input int s);
        @(negedge clk);
        bus.dayroll = 1'(dr);
        bus.freeze  = 1'(fr);
        bus.inc     = 1'(i);
        bus.dec     = 1'(d);
        bus.sel     = 2'(s);
        @(posedge clk);
        #1;
        model_step(dr, fr, i, d, s);
        cmp_model(tag);
        ny_count += int'(bus.newyear);
    endtask

    task automatic expect_date(input string tag, input int d, input int m, input int y);
        chk({tag, ".dd"}, int'(bus.dd), d);
        chk({tag, ".mo"}, int'(bus.mo), m);
        chk({tag, ".yy"}, int'(bus.yy), y);
    endtask

    // Load a date through the edit path: year, then month, then day.
    task automatic set_date(input int d, input int m, input int y);
        int n;
        n = (y - m_yy + 100) % 100;
        for (int k = 0; k < n; k++) step("set.yy", 0, 1, 1, 0, 3);
        n = (m - m_mo + 12) % 12;
        for (int k = 0; k < n; k++) step("set.mo", 0, 1, 1, 0, 2);
        n = (d - m_dd + mdays(m_mo, m_yy)) % mdays(m_mo, m_yy);
        for (int k = 0; k < n; k++) step("set.dd", 0, 1, 1, 0, 1);
        expect_date("set", d, m, y);
    endtask

    initial begin
        bus.dayroll = 1'b0;
        bus.freeze  = 1'b0;
        bus.inc     = 1'b0;
        bus.dec     = 1'b0;
        bus.sel     = 2'b00;
        ny_count    = 0;
        rst = 1'b1;
        model_reset();
        #3;
        expect_date("rst", 1, 1, 0);
        chk("rst.dim", int'(bus.dim), 31);
        chk("rst.ny", int'(bus.newyear), 0);
        @(negedge clk);
        rst = 1'b0;

        // Leap and non-leap February
        set_date(28, 2, 23);
        step("feb23", 1, 0, 0, 0, 0);
        expect_date("feb23", 1, 3, 23);
        set_date(28, 2, 24);
        step("feb24a", 1, 0, 0, 0, 0);
        expect_date("feb24a", 29, 2, 24);
        step("feb24b", 1, 0, 0, 0, 0);
        expect_date("feb24b", 1, 3, 24);

        // Year rollovers
        set_date(31, 12, 99);
        step("ny99", 1, 0, 0, 0, 0);
        expect_date("ny99", 1, 1, 0);
        chk("ny99.pulse", int'(bus.newyear), 1);
        step("ny99.after", 0, 0, 0, 0, 0);
        chk("ny99.drop", int'(bus.newyear), 0);
        set_date(31, 12, 5);
        step("ny05", 1, 0, 0, 0, 0);
        expect_date("ny05", 1, 1, 6);
        chk("ny05.pulse", int'(bus.newyear), 1);

        // Month ends
        set_date(30, 4, 6);
        step("apr", 1, 0, 0, 0, 0);
        expect_date("apr", 1, 5, 6);
        set_date(31, 1, 6);
        step("jan", 1, 0, 0, 0, 0);
        expect_date("jan", 1, 2, 6);
        set_date(30, 6, 6);
        step("jun", 1, 0, 0, 0, 0);
        expect_date("jun", 1, 7, 6);

        // A whole non-leap year with dayroll held high
        set_date(1, 1, 1);
        ny_count = 0;
        for (int k = 0; k < 365; k++) step("year", 1, 0, 0, 0, 0);
        expect_date("year", 1, 1, 2);
        chk("year.nycount", ny_count, 1);

        // Edits and clamping
        set_date(1, 2, 1);
        step("ed.day", 0, 1, 0, 1, 1);
        expect_date("ed.day", 28, 2, 1);
        set_date(31, 1, 1);
        step("ed.mon", 0, 1, 1, 0, 2);
        expect_date("ed.mon", 28, 2, 1);
        set_date(29, 2, 24);
        step("ed.yr", 0, 1, 1, 0, 3);
        expect_date("ed.yr", 28, 2, 25);
        step("ed.both", 0, 1, 1, 1, 1);
        expect_date("ed.both", 28, 2, 25);
        step("ed.sel0", 0, 1, 1, 0, 0);
        expect_date("ed.sel0", 28, 2, 25);
        step("ed.nony", 0, 1, 1, 0, 3);
        chk("ed.nony.pulse", int'(bus.newyear), 0);

        // Freeze blocks counting; edits ignored when running
        set_date(10, 5, 7);
        for (int k = 0; k < 3; k++) step("frz", 1, 1, 0, 0, 0);
        expect_date("frz", 10, 5, 7);
        step("run.inc", 0, 0, 1, 0, 1);
        step("run.dec", 0, 0, 0, 1, 2);
        expect_date("run", 10, 5, 7);
        step("rel", 1, 0, 0, 0, 0);
        expect_date("rel", 11, 5, 7);

        // Asynchronous reset in mid-cycle
        set_date(15, 8, 42);
        @(negedge clk);
        bus.dayroll = 1'b1;
        bus.freeze  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        expect_date("arst", 1, 1, 0);
        chk("arst.dim", int'(bus.dim), 31);
        chk("arst.ny", int'(bus.newyear), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.dayroll = 1'b0;

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            step("rnd", int'($urandom_range(0, 1)), int'($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
